// File: rtl/fifo_rd_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl_if
//   Read-side bundle of the dual-clock FIFO pointer logic. Carries the Gray
//   write pointer in from the write domain, the pop handshake, the RAM read
//   address and the status flags.
//
//   Signals
//     WrPtrGray_in   Gray write pointer from write domain (async to clk)
//     RdReq_in       pop request
//     RdEn_out       pop accepted this cycle / RAM read enable
//     RdAddr_out     binary RAM read address
//     RdPtrGray_out  registered Gray read pointer, returned to write domain
//     Empty_out      nothing visible to the read side
//     Level_out      words visible to the read side
//     Underflow_out  sticky pop-while-empty flag
//
//   Modports
//     slave  : the pointer controller
//     master : the reader / environment driving it
// -----------------------------------------------------------------------------
interface fifo_rd_ptr_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0]      WrPtrGray_in;
   logic                  RdReq_in;
   logic                  RdEn_out;
   logic [ADDR_WIDTH-1:0] RdAddr_out;
   logic [PTR_W-1:0]      RdPtrGray_out;
   logic                  Empty_out;
   logic [PTR_W-1:0]      Level_out;
   logic                  Underflow_out;

   modport slave (
      input  WrPtrGray_in,
      input  RdReq_in,
      output RdEn_out,
      output RdAddr_out,
      output RdPtrGray_out,
      output Empty_out,
      output Level_out,
      output Underflow_out
   );

   modport master (
      output WrPtrGray_in,
      output RdReq_in,
      input  RdEn_out,
      input  RdAddr_out,
      input  RdPtrGray_out,
      input  Empty_out,
      input  Level_out,
      input  Underflow_out
   );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
//   Read-side pointer controller of the dual-clock FIFO. Synchronises the Gray
//   write pointer into the read clock domain, decodes it to binary and derives
//   Empty/Level. Owns the binary read pointer (RAM address) and a registered
//   Gray copy of it that is handed back to the write domain.
//
//   Ports
//     clk       read-domain clock, everything on posedge
//     Clear_in  synchronous active-high clear of this side only
//     bus       fifo_rd_ptr_ctrl_if.slave (pointer in, pop handshake, status);
//               the interface ADDR_WIDTH must equal this module's ADDR_WIDTH
//
//   Parameters
//     ADDR_WIDTH   RAM address bits, depth = 2**ADDR_WIDTH
//     SYNC_STAGES  synchroniser depth on the write pointer, 2..4
// -----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               Clear_in,
   fifo_rd_ptr_ctrl_if.slave bus
);
   localparam int PTR_W = ADDR_WIDTH + 1;

   // Synchroniser chain: plain flops only, nothing between stages.
   logic [PTR_W-1:0] r_sync [SYNC_STAGES];
   logic [PTR_W-1:0] r_rbin;
   logic [PTR_W-1:0] r_rgray;
   logic             r_underflow;

   logic [PTR_W-1:0] w_wgray_s;
   logic [PTR_W-1:0] w_wbin_s;
   logic [PTR_W-1:0] w_rbin_nxt;
   logic             w_empty;
   logic             w_rd_en;

   assign w_wgray_s = r_sync[SYNC_STAGES-1];

   // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
   // NOTE: every bit is assigned on every pass, so no storage is inferred.
   always_comb begin
      w_wbin_s = '0;
      for (int i = 0; i < PTR_W; i++) begin
         w_wbin_s[i] = ^(w_wgray_s >> i);
      end
   end

   // The Gray pointers are compared directly: equal Gray codes mean equal
   // binary pointers, and the read side never sees a torn multi-bit value.
   assign w_empty    = (r_rgray == w_wgray_s);
   assign w_rd_en    = bus.RdReq_in & ~w_empty & ~Clear_in;
   assign w_rbin_nxt = r_rbin + 1'b1;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value, which the synchroniser chain depends on.
   always_ff @(posedge clk) begin
      if (Clear_in) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
         r_rbin      <= '0;
         r_rgray     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_sync[0] <= bus.WrPtrGray_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
         if (w_rd_en) begin
            // Gray copy is registered from the same incremented value so it
            // never glitches on its way to the write domain.
            r_rbin  <= w_rbin_nxt;
            r_rgray <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
         end
         // Sticky until the next clear; a refused pop leaves the pointer alone.
         if (bus.RdReq_in && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign bus.RdEn_out      = w_rd_en;
   assign bus.RdAddr_out    = r_rbin[ADDR_WIDTH-1:0];
   assign bus.RdPtrGray_out = r_rgray;
   assign bus.Empty_out     = w_empty;
   // Modular PTR_W-bit subtraction keeps the level right across pointer wrap.
   assign bus.Level_out     = w_wbin_s - r_rbin;
   assign bus.Underflow_out = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ptr_ctrl
//   Directed bench for fifo_rd_ptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
//   Each stimulus cycle pushes the outputs expected during that cycle (before
//   the closing edge) into a scoreboard queue; a monitor on the falling edge
//   pops one entry per cycle and compares the DUT outputs selected by a mask.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ptr_ctrl;
   localparam int ADDR_WIDTH = 4;
   localparam logic [5:0] ALL = 6'b111111;
   localparam logic [5:0] EN_ONLY = 6'b100000;

   logic clk;
   logic Clear_in;

   fifo_rd_ptr_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

   fifo_rd_ptr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .Clear_in(Clear_in),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mask bits: [5] RdEn [4] RdAddr [3] RdPtrGray [2] Empty [1] Level [0] Underflow
   typedef struct {
      string       nm;
      logic [5:0]  mask;
      logic        rden;
      logic [3:0]  addr;
      logic [4:0]  rgray;
      logic        empty;
      logic [4:0]  level;
      logic        uf;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   exp_t cur;
   logic bad;

   function automatic logic [4:0] gray(input int v);
      logic [4:0] b;
      b = v[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic apply(input logic clr, input logic req, input logic [4:0] wg,
                        input string nm, input logic [5:0] mask,
                        input logic rden, input logic [3:0] addr,
                        input logic [4:0] rgray, input logic empty,
                        input logic [4:0] level, input logic uf);
      exp_t e;
      Clear_in         = clr;
      bus.RdReq_in     = req;
      bus.WrPtrGray_in = wg;
      e.nm    = nm;
      e.mask  = mask;
      e.rden  = rden;
      e.addr  = addr;
      e.rgray = rgray;
      e.empty = empty;
      e.level = level;
      e.uf    = uf;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         vectors++;
         bad = 1'b0;
         if (cur.mask[5] && bus.RdEn_out      !== cur.rden)  bad = 1'b1;
         if (cur.mask[4] && bus.RdAddr_out    !== cur.addr)  bad = 1'b1;
         if (cur.mask[3] && bus.RdPtrGray_out !== cur.rgray) bad = 1'b1;
         if (cur.mask[2] && bus.Empty_out     !== cur.empty) bad = 1'b1;
         if (cur.mask[1] && bus.Level_out     !== cur.level) bad = 1'b1;
         if (cur.mask[0] && bus.Underflow_out !== cur.uf)    bad = 1'b1;
         if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got en=%b addr=%0d gray=%b empty=%b level=%0d uf=%b; want en=%b addr=%0d gray=%b empty=%b level=%0d uf=%b (mask %b)",
                     cur.nm, $time, bus.RdEn_out, bus.RdAddr_out, bus.RdPtrGray_out,
                     bus.Empty_out, bus.Level_out, bus.Underflow_out,
                     cur.rden, cur.addr, cur.rgray, cur.empty, cur.level, cur.uf, cur.mask);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, %0d vectors applied", vectors);
      $fatal(1, "timeout");
   end

   initial begin
      Clear_in         = 1'b0;
      bus.RdReq_in     = 1'b0;
      bus.WrPtrGray_in = 5'b00010;
      @(posedge clk);
      #1;

      // Reset: two clear cycles with a pending request and a nonzero write pointer
      apply('1, '1, 5'b00010, "clr_rden",  EN_ONLY, '0, 4'd0, 5'd0, '0, 5'd0, '0);
      apply('1, '1, 5'b00010, "clr_state", ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00010, "rel_hold",  ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00010, "rel_edge1", ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00010, "rel_edge2", ALL, '0, 4'd0, 5'd0, '0, 5'd3, '0);

      // Back to idle zero, then sync latency of a single write-pointer step
      apply('1, '0, 5'b00000, "clr2",      ALL, '0, 4'd0, 5'd0, '0, 5'd3, '0);
      apply('0, '0, 5'b00000, "idle0",     ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00001, "lat_pre",   ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00001, "lat_t",     ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b00010, "lat_t1",    ALL, '0, 4'd0, 5'd0, '0, 5'd1, '0);

      // Drain three words
      apply('0, '0, 5'b00010, "ld3",       ALL, '0, 4'd0, 5'd0, '0, 5'd1, '0);
      for (int i = 0; i < 3; i++)
         apply('0, '1, 5'b00010, "drain",  ALL, '1, 4'(i), gray(i), '0, 5'(3 - i), '0);
      apply('0, '0, 5'b00010, "drained",   ALL, '0, 4'd3, 5'b00010, '1, 5'd0, '0);

      // Underflow: refused pop, sticky flag, cleared only by Clear_in
      apply('0, '1, 5'b00010, "uf_req",    ALL, '0, 4'd3, 5'b00010, '1, 5'd0, '0);
      for (int i = 0; i < 10; i++)
         apply('0, '0, 5'b00010, "uf_hold", ALL, '0, 4'd3, 5'b00010, '1, 5'd0, '1);
      apply('1, '0, 5'b00000, "uf_clr",    ALL, '0, 4'd3, 5'b00010, '1, 5'd0, '1);

      // Wrap: fill to 16, drain 16, advance to 31, drain 15
      apply('0, '0, 5'b11000, "wrap_idle", ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      apply('0, '0, 5'b11000, "wrap_sync", ALL, '0, 4'd0, 5'd0, '1, 5'd0, '0);
      for (int i = 0; i < 16; i++)
         apply('0, '1, 5'b11000, "pop16",  ALL, '1, 4'(i), gray(i), '0, 5'(16 - i), '0);
      apply('0, '0, 5'b10000, "wrap16",    ALL, '0, 4'd0, 5'b11000, '1, 5'd0, '0);
      apply('0, '0, 5'b10000, "wrap16_s",  ALL, '0, 4'd0, 5'b11000, '1, 5'd0, '0);
      for (int j = 0; j < 15; j++)
         apply('0, '1, 5'b10000, "pop15",  ALL, '1, 4'(j), gray(16 + j), '0, 5'(15 - j), '0);

      // Write pointer 31->0 then 0->1; pop on the edge the synced pointer advances
      apply('0, '0, 5'b00000, "at31",      ALL, '0, 4'd15, 5'b10000, '1, 5'd0, '0);
      apply('0, '0, 5'b00001, "wr_adv",    ALL, '0, 4'd15, 5'b10000, '1, 5'd0, '0);
      apply('0, '1, 5'b00001, "simul",     ALL, '1, 4'd15, 5'b10000, '0, 5'd1, '0);
      apply('0, '0, 5'b00001, "post_sim",  ALL, '0, 4'd0, 5'b00000, '0, 5'd1, '0);
      apply('0, '1, 5'b00001, "last_pop",  ALL, '1, 4'd0, 5'b00000, '0, 5'd1, '0);
      apply('0, '0, 5'b00001, "end_empty", ALL, '0, 4'd1, 5'b00001, '1, 5'd0, '0);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
